issue_sched: RTL
================

ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter: bs, default 16, number of instruction-buffer slots; bs_bits = $clog2(bs).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alloc_valid  input  1  new instruction written into slot alloc_index this cycle.
REQ-005 alloc_index  input  bs_bits  target slot of allocation.
REQ-006 alloc_idt  input  bs  dependency vector of the new instruction; bit j set = depends on slot j.
REQ-007 alloc_ready  output  1  combinational; 1 when slot alloc_index is FREE.
REQ-008 issue_valid  output  1  registered; an issuable slot is presented.
REQ-009 issue_index  output  bs_bits  registered; presented slot, meaningful only while issue_valid=1.
REQ-010 issue_ready  input  1  consumer accepts presented slot; handshake fires when issue_valid & issue_ready.
REQ-011 complete_valid  input  1  slot complete_index finished execution.
REQ-012 complete_index  input  bs_bits  completing slot.
REQ-013 occupied  output  bs  bit i = slot i not FREE.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Each slot SHALL hold one state: FREE, WAIT, READY, ISSUED, plus dependency row dep[i][0..bs-1] and an age matrix recording relative allocation order.
REQ-016 Accepted alloc (alloc_valid & alloc_ready): dep[alloc_index] = alloc_idt & live & ~self_bit; live = slots in WAIT/READY/ISSUED not completing this cycle; slot -> WAIT if row nonzero, else READY; slot becomes youngest.
REQ-017 Masking by live SHALL discard stale bits in alloc_idt (including all-ones vectors after dependency-table reset).
REQ-018 Completion (complete_valid, slot in ISSUED): column complete_index cleared in every row; slot -> FREE; same edge.
REQ-019 WAIT slot whose row becomes zero SHALL move to READY at the edge following the clearing edge's state, i.e. readiness evaluated combinationally from post-update row: READY visible one cycle after completion edge.
REQ-020 Handshake fire: presented slot -> ISSUED at that edge.
REQ-021 Selection: oldest READY slot per age matrix, excluding a slot firing this cycle; ties impossible.
REQ-022 issue_valid/issue_index SHALL hold stable while issue_valid & ~issue_ready; new selection loaded only when not presenting or on fire.
REQ-023 Latency: alloc with no live deps at edge E, no other READY slot -> issue_valid=1 after edge E+1; producer completion at edge E -> sole dependant presented after edge E+1.
REQ-024 Back-to-back: on fire at edge E, next oldest READY slot presented after edge E (no bubble).
REQ-025 alloc_valid with slot not FREE: ignored, err set.
REQ-026 complete_valid for slot not ISSUED: ignored, err set.
REQ-027 Same-cycle alloc and completion of producer j: new row excludes j; no lost wakeup.
REQ-028 Same-cycle alloc and completion of same slot: alloc rejected (alloc_ready reflects pre-edge state), err set.
REQ-029 occupied SHALL reflect registered state (pre-edge).

Reset
REQ-030 rst=1 at edge: all slots FREE, dep and age matrices cleared, issue_valid=0, issue_index=0, err=0; other inputs ignored that cycle.
REQ-031 rst mid-operation SHALL drop all in-flight slots and any presented issue without completion.

Verification
REQ-032 Alloc slot 3, idt=0, issue_ready=1 -> issue_valid=1, issue_index=3 two edges later; slot 3 ISSUED; complete 3 -> occupied=0.
REQ-033 Alloc slot 0 (idt=0) then slot 5 (idt=0x0001), hold issue_ready=0 -> index 0 held stable; accept, complete 0 -> slot 5 presented one edge after completion.
REQ-034 Alloc slots 7 then 2 (idt=0 both) -> issue order 7, 2 (age, not index).
REQ-035 After reset, alloc slot 1 with idt=0xFFFF -> READY immediately (stale bits masked), presented next edge.
REQ-036 Alloc to occupied slot 4; complete slot 6 while FREE -> err=1 sticky, state unchanged; rst -> err=0.
REQ-037 Alloc slot 9 with idt bit 2 same cycle as completion of slot 2 -> slot 9 READY, presented next edge.

Source files
------------

// File: rtl/issue_sched_if.sv
// rtl/issue_sched_if.sv - allocation, issue and completion bus of the issue scheduler
//   alloc_valid/alloc_index/alloc_idt : new instruction into a slot, with its dependency vector
//   alloc_ready                        : addressed slot is FREE
//   issue_valid/issue_index            : presented issuable slot
//   issue_ready                        : consumer accepts the presented slot
//   complete_valid/complete_index      : slot finished execution
//   occupied                           : per-slot not-FREE flags
//   err                                : sticky protocol-error flag
//   modport slave  : scheduler side
//   modport master : producer/consumer side
interface issue_sched_if #(
   parameter int bs = 16
);
   localparam int bs_bits = $clog2(bs);

   logic               alloc_valid;
   logic [bs_bits-1:0] alloc_index;
   logic [bs-1:0]      alloc_idt;
   logic               alloc_ready;
   logic               issue_valid;
   logic [bs_bits-1:0] issue_index;
   logic               issue_ready;
   logic               complete_valid;
   logic [bs_bits-1:0] complete_index;
   logic [bs-1:0]      occupied;
   logic               err;

   modport slave (
      input  alloc_valid, alloc_index, alloc_idt, issue_ready, complete_valid, complete_index,
      output alloc_ready, issue_valid, issue_index, occupied, err
   );

   modport master (
      output alloc_valid, alloc_index, alloc_idt, issue_ready, complete_valid, complete_index,
      input  alloc_ready, issue_valid, issue_index, occupied, err
   );
endinterface

// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - dependency-tracking issue scheduler over an instruction buffer
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : issue_sched_if.slave (alloc, issue handshake, completion, occupied, err)
// Each slot is FREE/WAIT/READY/ISSUED with a dependency row and an age-matrix row.
// The oldest READY slot is presented through a registered valid/index pair.
module issue_sched #(
   parameter int bs = 16
) (
   input  logic          clk,
   input  logic          rst,
   issue_sched_if.slave  bus
);
   localparam int bs_bits = $clog2(bs);

   typedef enum logic [1:0] {
      S_FREE,
      S_WAIT,
      S_READY,
      S_ISSUED
   } slot_state_t;

   slot_state_t state_q [bs];
   slot_state_t state_d [bs];

   // dep_q[i][j]: slot i waits on slot j.  age_q[i][j]: slot i was allocated before slot j.
   logic [bs-1:0][bs-1:0] dep_q, dep_d;
   logic [bs-1:0][bs-1:0] age_q, age_d;

   logic               issue_valid_q, issue_valid_d;
   logic [bs_bits-1:0] issue_index_q, issue_index_d;
   logic               err_q, err_d;

   logic               alloc_ok;
   logic               comp_ok;
   logic               fire;
   logic [bs-1:0]      occ;
   logic [bs-1:0]      live;
   logic [bs-1:0]      ready_vec;
   logic [bs-1:0]      older_ready;
   logic               sel_found;
   logic [bs_bits-1:0] sel_idx;

   assign fire            = issue_valid_q & bus.issue_ready;
   assign bus.alloc_ready = (state_q[bus.alloc_index] == S_FREE);
   assign alloc_ok        = bus.alloc_valid & bus.alloc_ready;
   assign comp_ok         = bus.complete_valid & (state_q[bus.complete_index] == S_ISSUED);

   // live excludes a slot completing this edge so a same-cycle allocation cannot
   // latch a dependency whose wakeup is happening right now.
   // ready_vec excludes the slot being accepted so the next pick is a different one.
   always_comb begin
      occ       = '0;
      live      = '0;
      ready_vec = '0;
      for (int i = 0; i < bs; i++) begin
         occ[i]       = (state_q[i] != S_FREE);
         live[i]      = occ[i] && !(comp_ok && (bus.complete_index == bs_bits'(i)));
         ready_vec[i] = (state_q[i] == S_READY) && !(fire && (issue_index_q == bs_bits'(i)));
      end
   end

   // A READY slot is the oldest when no other READY slot is older than it.
   always_comb begin
      older_ready = '0;
      sel_found   = 1'b0;
      sel_idx     = '0;
      for (int i = 0; i < bs; i++) begin
         for (int j = 0; j < bs; j++) begin
            older_ready[i] = older_ready[i] | (ready_vec[j] & age_q[j][i]);
         end
      end
      for (int i = 0; i < bs; i++) begin
         if (ready_vec[i] && !older_ready[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = bs_bits'(i);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      dep_d         = dep_q;
      age_d         = age_q;
      err_d         = err_q;
      issue_valid_d = issue_valid_q;
      issue_index_d = issue_index_q;

      if (comp_ok) begin
         state_d[bus.complete_index] = S_FREE;
         for (int i = 0; i < bs; i++) begin
            dep_d[i][bus.complete_index] = 1'b0;
         end
      end

      if (fire) begin
         state_d[issue_index_q] = S_ISSUED;
      end

      if (alloc_ok) begin
         dep_d[bus.alloc_index]                  = bus.alloc_idt & live;
         dep_d[bus.alloc_index][bus.alloc_index] = 1'b0;
         state_d[bus.alloc_index]                = S_WAIT;
         // every other slot becomes older than the new one; the new row is cleared
         // last so the diagonal stays zero
         for (int j = 0; j < bs; j++) begin
            age_d[j][bus.alloc_index] = 1'b1;
         end
         age_d[bus.alloc_index] = '0;
      end

      // Wakeup uses the post-update rows, covering both a fresh allocation with
      // no live producers and a waiter whose last producer completes now.
      for (int i = 0; i < bs; i++) begin
         if ((state_d[i] == S_WAIT) && (dep_d[i] == '0)) begin
            state_d[i] = S_READY;
         end
      end

      if ((bus.alloc_valid && !bus.alloc_ready) || (bus.complete_valid && !comp_ok)) begin
         err_d = 1'b1;
      end

      // The presented pair only reloads when idle or on acceptance, so it stays
      // stable while the consumer stalls.
      if (!issue_valid_q || fire) begin
         issue_valid_d = sel_found;
         issue_index_d = sel_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < bs; i++) begin
            state_q[i] <= S_FREE;
         end
         dep_q         <= '0;
         age_q         <= '0;
         issue_valid_q <= 1'b0;
         issue_index_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         dep_q         <= dep_d;
         age_q         <= age_d;
         issue_valid_q <= issue_valid_d;
         issue_index_q <= issue_index_d;
         err_q         <= err_d;
      end
   end

   assign bus.issue_valid = issue_valid_q;
   assign bus.issue_index = issue_index_q;
   assign bus.occupied    = occ;
   assign bus.err         = err_q;
endmodule
